// File: rtl/synth_pkg.sv
// Shared constants for the synth audio path.
//   CodeWidthDefault        : default width of the scaled duty code
//   UnderrunCntWidthDefault : default width of the saturating underrun counter
//   midscale()              : half-scale code for a given code width
package synth_pkg;

    localparam int unsigned CodeWidthDefault        = 10;
    localparam int unsigned UnderrunCntWidthDefault = 16;

    // 2^(width-1): the idle code that yields a 50% duty PWM frame.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/pwm_modulator.sv
// Fixed-frame PWM core: free-running frame counter, active duty code and
// registered compare output.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : latch code_in_i as the active code at the frame boundary
//   code_in_i   : next duty code
//   boundary_o  : high on the last cycle of a frame (counter at all-ones)
//   pwm_o       : registered PWM bit, one cycle behind counter/code
module pwm_modulator
    import synth_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = CodeWidthDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [CODE_WIDTH-1:0] code_in_i,
    output logic                  boundary_o,
    output logic                  pwm_o
);

    localparam logic [CODE_WIDTH-1:0] CntMax  = '1;
    localparam logic [CODE_WIDTH-1:0] CodeMid = CODE_WIDTH'(midscale(CODE_WIDTH));

    logic [CODE_WIDTH-1:0] cnt_q, cnt_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;
    logic                  pwm_q, pwm_d;

    always_comb begin
        boundary_o = (cnt_q == CntMax);
        // Counter wraps naturally from all-ones to zero.
        cnt_d      = cnt_q + 1'b1;
        code_d     = code_q;
        if (load_i) begin
            code_d = code_in_i;
        end
        // Counter never exceeds CntMax, so a full-scale code still leaves one low cycle.
        pwm_d = (cnt_q < code_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            code_q <= CodeMid;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            code_q <= code_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_dac_sampler.sv
// PWM DAC output stage: one-entry input buffer behind a valid/ready handshake,
// feeding a fixed-frame PWM modulator; one sample is consumed per frame.
//   clk, rst             : clock, synchronous active-high reset
//   synth_valid_i        : producer holds a valid code
//   synth_ready_o        : buffer empty, a code can be accepted this cycle
//   scaled_synth_code_i  : unsigned duty code
//   pwm_out_o            : registered PWM bit toward the IOB flop
//   frame_start_o        : one-cycle pulse as a new frame (and code) begins
//   underrun_o           : one-cycle pulse when a frame began with no sample
//   underrun_count_o     : saturating underrun total since reset
module pwm_dac_sampler
    import synth_pkg::*;
#(
    parameter int unsigned CODE_WIDTH         = CodeWidthDefault,
    parameter int unsigned UNDERRUN_CNT_WIDTH = UnderrunCntWidthDefault
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          synth_valid_i,
    output logic                          synth_ready_o,
    input  logic [CODE_WIDTH-1:0]         scaled_synth_code_i,
    output logic                          pwm_out_o,
    output logic                          frame_start_o,
    output logic                          underrun_o,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count_o
);

    logic [CODE_WIDTH-1:0]         buf_q, buf_d;
    logic                          buf_full_q, buf_full_d;
    logic                          frame_start_q, frame_start_d;
    logic                          underrun_q, underrun_d;
    logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count_q, underrun_count_d;

    logic boundary;
    logic load;
    logic xfer;

    pwm_modulator #(
        .CODE_WIDTH(CODE_WIDTH)
    ) u_pwm_modulator (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .code_in_i (buf_q),
        .boundary_o(boundary),
        .pwm_o     (pwm_out_o)
    );

    always_comb begin
        synth_ready_o    = !buf_full_q;
        xfer             = synth_valid_i && !buf_full_q;
        load             = boundary && buf_full_q;

        buf_d            = buf_q;
        buf_full_d       = buf_full_q;
        frame_start_d    = boundary;
        underrun_d       = boundary && !buf_full_q;
        underrun_count_d = underrun_count_q;

        // Load and transfer are exclusive: a full buffer holds ready low. A transfer on
        // an empty-buffer boundary only fills the buffer for the next frame.
        if (load) begin
            buf_full_d = 1'b0;
        end else if (xfer) begin
            buf_d      = scaled_synth_code_i;
            buf_full_d = 1'b1;
        end

        if (underrun_d && (underrun_count_q != '1)) begin
            underrun_count_d = underrun_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q            <= '0;
            buf_full_q       <= 1'b0;
            frame_start_q    <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            buf_q            <= buf_d;
            buf_full_q       <= buf_full_d;
            frame_start_q    <= frame_start_d;
            underrun_q       <= underrun_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign frame_start_o    = frame_start_q;
    assign underrun_o       = underrun_q;
    assign underrun_count_o = underrun_count_q;

endmodule

// File: tb/tb_pwm_dac_sampler.sv
// Bench for pwm_dac_sampler with a 16-cycle frame and a 2-bit underrun counter.
// Stimulus pushes one expected record per PWM frame; the monitor delimits frames
// by frame_start and compares high-cycle count, underrun pulses and counter value.
module tb_pwm_dac_sampler;

    localparam int unsigned CW  = 4;
    localparam int unsigned UCW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           synth_valid = 1'b0;
    logic           synth_ready;
    logic [CW-1:0]  scaled_synth_code = '0;
    logic           pwm_out;
    logic           frame_start;
    logic           underrun;
    logic [UCW-1:0] underrun_count;

    pwm_dac_sampler #(
        .CODE_WIDTH        (CW),
        .UNDERRUN_CNT_WIDTH(UCW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .synth_valid_i      (synth_valid),
        .synth_ready_o      (synth_ready),
        .scaled_synth_code_i(scaled_synth_code),
        .pwm_out_o          (pwm_out),
        .frame_start_o      (frame_start),
        .underrun_o         (underrun),
        .underrun_count_o   (underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int high;
        int ur;
        int ucnt;
    } frame_t;

    frame_t exp_q[$];
    int     n_cmp  = 0;
    int     n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int high, input int ur, input int ucnt);
        frame_t f;
        f.high = high;
        f.ur   = ur;
        f.ucnt = ucnt;
        exp_q.push_back(f);
    endtask

    // Monitor: pwm_out lags the counter by one cycle, so the frame_start cycle's pwm
    // sample still belongs to the frame that just ended.
    int  mon_frame = 0;
    bit  in_prog   = 1'b0;
    int  cur_high, cur_ur, cur_ucnt;

    always @(negedge clk) begin
        if (rst) begin
            in_prog = 1'b0;
        end else if (frame_start) begin
            if (in_prog) begin
                cur_high += int'(pwm_out);
                mon_frame++;
                if (exp_q.size() == 0) begin
                    check($sformatf("frame%0d unexpected", mon_frame), 1, 0);
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    check($sformatf("frame%0d pwm_high", mon_frame), cur_high, e.high);
                    check($sformatf("frame%0d underrun_pulses", mon_frame), cur_ur, e.ur);
                    check($sformatf("frame%0d underrun_count", mon_frame), cur_ucnt, e.ucnt);
                end
            end
            in_prog  = 1'b1;
            cur_high = 0;
            cur_ur   = int'(underrun);
            cur_ucnt = int'(underrun_count);
        end else if (in_prog) begin
            cur_high += int'(pwm_out);
            cur_ur   += int'(underrun);
        end
    end

    task automatic wait_frame_start(input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        check({name, " frame_start timeout"}, 0, 1);
    endtask

    // Holds valid/data until a cycle with ready; returns just after the accepting edge.
    task automatic send(input logic [CW-1:0] code);
        synth_valid       = 1'b1;
        scaled_synth_code = code;
        for (int i = 0; i < 64; i++) begin
            if (synth_ready) begin
                @(posedge clk);
                #1;
                synth_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        synth_valid = 1'b0;
        check($sformatf("send %0d accept timeout", code), 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pwm_out"}, int'(pwm_out), 0);
        check({tag, " synth_ready"}, int'(synth_ready), 1);
        check({tag, " frame_start"}, int'(frame_start), 0);
        check({tag, " underrun"}, int'(underrun), 0);
        check({tag, " underrun_count"}, int'(underrun_count), 0);
    endtask

    // Cycles from reset release (cnt=0 cycle) to the first frame_start.
    task automatic check_restart(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
        end
        check({tag, " cycles to first frame_start"}, n, 16);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Idle: midscale repeats, one underrun per frame, counter saturates at 3.
        push(8, 1, 1);
        push(8, 1, 2);
        push(8, 1, 3);
        push(8, 1, 3);
        push(8, 1, 3);
        push(8, 1, 3);
        rst = 1'b0;
        check_restart("release");
        repeat (5) wait_frame_start("idle");

        // Stream 0, 5, 15; later codes wait under back-pressure until a drain.
        push(0, 0, 3);
        push(5, 0, 3);
        push(15, 0, 3);
        send(4'd0);
        send(4'd5);
        send(4'd15);

        // Boundary race: transfer of 3 on the last cycle of an empty-buffer frame.
        push(15, 1, 3);
        push(3, 0, 3);
        wait_frame_start("race");
        repeat (15) @(negedge clk);
        send(4'd3);

        // Active code 9, buffer holding 12, then reset mid-frame.
        send(4'd9);
        send(4'd12);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        push(8, 1, 1);
        push(8, 1, 2);
        rst = 1'b0;
        check_restart("midreset release");

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("pending frames", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
